// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - wrap/threshold event detector with timestamped show-ahead event FIFO
//
// Purpose: watches a load/count counter stage (count_valid_i/count_value_i),
// flags wrap-around (all-ones -> 0 while counting) and threshold entry, and
// queues each event with a free-running timestamp for a valid/ready consumer.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous reset, active-high
//   enable_i       1 = detected events are queued (detection always runs)
//   threshold_i    match value, sampled every cycle
//   count_valid_i  observed counter is counting (0 = load cycle)
//   count_value_i  observed counter value
//   evt_valid_o    FIFO head valid
//   evt_ready_i    consumer accepts head
//   evt_type_o     head type: 01 wrap, 10 match, 11 both
//   evt_value_o    head count value
//   evt_ts_o       head timestamp (detect cycle)
//   fifo_level_o   occupied entries, 0..DEPTH
//   ovf_o          sticky overflow flag
//   ovf_count_o    dropped-event count, saturating
//   clr_ovf_i      clears ovf_o / ovf_count_o

module count_event_monitor #(
  parameter int CNT_W = 4,
  parameter int TS_W  = 8,
  parameter int DEPTH = 4,
  parameter int OVF_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [CNT_W-1:0]         threshold_i,
  input  logic                     count_valid_i,
  input  logic [CNT_W-1:0]         count_value_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [1:0]               evt_type_o,
  output logic [CNT_W-1:0]         evt_value_o,
  output logic [TS_W-1:0]          evt_ts_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     ovf_o,
  output logic [OVF_W-1:0]         ovf_count_o,
  input  logic                     clr_ovf_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 + CNT_W + TS_W;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] prev_value_q, prev_value_d;
  logic             prev_valid_q, prev_valid_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic          wrap;
  logic          match;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          drop;
  logic [EW-1:0] head;

  always_comb begin
    ts_d         = ts_q + TS_W'(1);
    prev_value_d = prev_value_q;
    prev_valid_d = 1'b0;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    ovf_d        = ovf_q;
    ovf_cnt_d    = ovf_cnt_q;

    // History only follows counting cycles; a load cycle breaks the chain so
    // a load to 0 right after all-ones is never mistaken for a wrap.
    if (count_valid_i) begin
      prev_value_d = count_value_i;
      prev_valid_d = 1'b1;
    end

    wrap  = count_valid_i & prev_valid_q & (prev_value_q == '1) &
            (count_value_i == '0);
    // Fires only on entry to the threshold value, not while it holds.
    match = count_valid_i & (count_value_i == threshold_i) &
            ~(prev_valid_q & (prev_value_q == count_value_i));

    push_req = (wrap | match) & enable_i;
    pop      = (level_q != '0) & evt_ready_i;
    full     = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;

    if (push) begin
      mem_d[wr_ptr_q] = {match, wrap, count_value_i, ts_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);

    // A drop in the same cycle as a clear wins: the count restarts at 1.
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf_i) begin
        ovf_cnt_d = OVF_W'(1);
      end else if (ovf_cnt_q != '1) begin
        ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
      end
    end else if (clr_ovf_i) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q         <= '0;
      prev_value_q <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      ts_q         <= ts_d;
      prev_value_q <= prev_value_d;
      prev_valid_q <= prev_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ovf_q        <= ovf_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head         = mem_q[rd_ptr_q];
  assign evt_valid_o  = (level_q != '0);
  assign evt_type_o   = evt_valid_o ? head[EW-1 -: 2] : 2'b00;
  assign evt_value_o  = evt_valid_o ? head[TS_W +: CNT_W] : '0;
  assign evt_ts_o     = evt_valid_o ? head[TS_W-1:0] : '0;
  assign fifo_level_o = level_q;
  assign ovf_o        = ovf_q;
  assign ovf_count_o  = ovf_cnt_q;

endmodule
